// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, then one command byte shifted out
// on device-generated clock edges, finishing with a check of the device acknowledge.
module ps2_tx #(
    parameter int RTS_CYCLES     = 5000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    input  logic       rx_idle,
    inout  wire        ps2d,
    inout  wire        ps2c,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err
);

    localparam int RTS_W = $clog2(RTS_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        RTS,
        START,
        DATA,
        STOP
    } state_t;

    state_t                state;
    logic [RTS_W-1:0]      rts_cnt;
    logic [TMO_W-1:0]      tmo;
    logic [3:0]            n;
    logic [8:0]            frame;
    logic                  c_oe;
    logic                  d_oe;

    logic [FILTER_LEN-1:0] filt_p0;
    logic                  fclk_p0;
    logic                  fclk_next;
    logic                  fall_edge_p1;

    logic                  load_frame;
    logic                  shift_frame;
    logic                  tmo_hit;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    // Stage p0: raw clock shift register and hysteretic filtered clock
    always_comb begin
        fclk_next = fclk_p0;
        if (&filt_p0)
            fclk_next = 1'b1;
        else if (~|filt_p0)
            fclk_next = 1'b0;
    end

    // Stage p1: one-cycle tick on a filtered 1->0 transition
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_p0      <= '1;
            fclk_p0      <= 1'b1;
            fall_edge_p1 <= 1'b0;
        end else begin
            filt_p0      <= {ps2c, filt_p0[FILTER_LEN-1:1]};
            fclk_p0      <= fclk_next;
            fall_edge_p1 <= fclk_p0 & ~fclk_next;
        end
    end

    assign load_frame  = (state == IDLE) && wr_ps2 && rx_idle;
    assign shift_frame = (state == DATA) && fall_edge_p1 && (n != 4'd0);

    // The fall_edge cycle itself counts as cycle zero, so the abort lands
    // exactly TIMEOUT_CYCLES cycles after the last fall_edge tick.
    assign tmo_hit = (tmo == TMO_W'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge clk) begin
        if (load_frame)
            frame <= {odd_parity(din), din};
        else if (shift_frame)
            frame <= {1'b0, frame[8:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rts_cnt      <= '0;
            tmo          <= '0;
            n            <= 4'd0;
            c_oe         <= 1'b0;
            d_oe         <= 1'b0;
            tx_done_tick <= 1'b0;
            tx_err       <= 1'b0;
        end else begin
            tx_done_tick <= 1'b0;
            tx_err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_frame) begin
                        rts_cnt <= RTS_W'(RTS_CYCLES - 1);
                        c_oe    <= 1'b1;
                        state   <= RTS;
                    end
                end
                RTS: begin
                    if (rts_cnt == '0) begin
                        c_oe  <= 1'b0;
                        d_oe  <= 1'b1;
                        n     <= 4'd8;
                        tmo   <= '0;
                        state <= START;
                    end else begin
                        rts_cnt <= rts_cnt - RTS_W'(1);
                    end
                end
                START, DATA, STOP: begin
                    if (fall_edge_p1) begin
                        tmo <= '0;
                        if (state == START) begin
                            d_oe  <= ~frame[0];
                            state <= DATA;
                        end else if (state == DATA) begin
                            if (n != 4'd0) begin
                                d_oe <= ~frame[1];
                                n    <= n - 4'd1;
                            end else begin
                                d_oe  <= 1'b0;
                                state <= STOP;
                            end
                        end else begin
                            // ack is the device pulling data low on the 11th edge
                            if (ps2d == 1'b0)
                                tx_done_tick <= 1'b1;
                            else
                                tx_err <= 1'b1;
                            state <= IDLE;
                        end
                    end else if (tmo_hit) begin
                        tx_err <= 1'b1;
                        c_oe   <= 1'b0;
                        d_oe   <= 1'b0;
                        tmo    <= '0;
                        state  <= IDLE;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end
                default: begin
                    c_oe  <= 1'b0;
                    d_oe  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ps2c    = c_oe ? 1'b0 : 1'bz;
    assign ps2d    = d_oe ? 1'b0 : 1'bz;
    assign tx_idle = (state == IDLE);

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a behavioural PS/2 device clocks frames out of the DUT while a
// scoreboard matches each done/err pulse against the queued expected outcome.
module tb_ps2_tx;

    localparam int RTS = 20;
    localparam int TMO = 500;
    localparam int FL  = 8;
    localparam int H   = 25;

    localparam int K_DONE = 0;
    localparam int K_NACK = 1;
    localparam int K_TMO  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_ps2 = 1'b0;
    logic       rx_idle = 1'b1;
    logic [7:0] din = 8'h00;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_err;
    wire        ps2d_w;
    wire        ps2c_w;

    logic dev_c = 1'b0;
    logic dev_d = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_fall_cyc = 0;

    typedef struct {
        logic [7:0] data;
        int         kind;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stp;
    } frm_t;

    exp_t exp_q[$];
    frm_t rx_q[$];
    exp_t mon_e;
    frm_t mon_f;

    pullup (ps2c_w);
    pullup (ps2d_w);
    assign ps2c_w = dev_c ? 1'b0 : 1'bz;
    assign ps2d_w = dev_d ? 1'b0 : 1'bz;

    ps2_tx #(
        .RTS_CYCLES    (RTS),
        .FILTER_LEN    (FL),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_ps2      (wr_ps2),
        .din         (din),
        .rx_idle     (rx_idle),
        .ps2d        (ps2d_w),
        .ps2c        (ps2c_w),
        .tx_idle     (tx_idle),
        .tx_done_tick(tx_done_tick),
        .tx_err      (tx_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Odd parity by counting ones: parity bit set when the byte has an even count.
    function automatic logic model_parity(input logic [7:0] b);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return (ones % 2) == 0;
    endfunction

    task automatic expect_result(input logic [7:0] b, input int kind);
        exp_t e;
        e.data = b;
        e.kind = kind;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [7:0] b, input bit rxi);
        @(negedge clk);
        din = b;
        rx_idle = rxi;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        rx_idle = 1'b1;
        din = 8'($urandom);
        check("tx_idle_after_wr", 32'(tx_idle), 32'(!rxi));
    endtask

    // Device side: measure request-to-send, then generate n_edges clock pulses,
    // sampling data just before each rising edge and acking on edge 11.
    task automatic dev_xfer(input int n_edges, input bit ack, input bit glitch);
        int   cnt;
        int   low;
        logic [10:0] bits;
        frm_t f;
        bits = '0;
        cnt = 0;
        while (ps2c_w !== 1'b0 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("rts_seen", 32'(ps2c_w), 32'(0));
        low = 0;
        while (ps2c_w === 1'b0 && low < 1000) begin
            low++;
            @(negedge clk);
        end
        check("rts_len", 32'(low), 32'(RTS));
        check("start_bit", 32'(ps2d_w), 32'(0));
        repeat (20) @(negedge clk);
        for (int e = 1; e <= n_edges; e++) begin
            if (e == 11) dev_d = ack;
            dev_c = 1'b1;
            last_fall_cyc = cyc;
            repeat (H) @(negedge clk);
            if (e <= 10) bits[e-1] = ps2d_w;
            if (e == 10 && n_edges == 11) begin
                f.data = bits[7:0];
                f.par  = bits[8];
                f.stp  = bits[9];
                rx_q.push_back(f);
            end
            dev_c = 1'b0;
            if (glitch && e >= 2 && e <= 9) begin
                int g;
                g = int'($urandom_range(1, 7));
                repeat (10) @(negedge clk);
                dev_c = 1'b1;
                repeat (g) @(negedge clk);
                dev_c = 1'b0;
                repeat (H - 10 - g) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
            if (e == 11) dev_d = 1'b0;
        end
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'(0));
        repeat (3) @(negedge clk);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && (tx_done_tick || tx_err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, tx_done_tick, tx_err}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_kind", {30'd0, tx_done_tick, tx_err},
                      (mon_e.kind == K_DONE) ? 32'd2 : 32'd1);
                check("idle_at_pulse", 32'(tx_idle), 32'(1));
                if (mon_e.kind == K_TMO) begin
                    check("timeout_latency", 32'(cyc - last_fall_cyc), 32'(FL + 1 + TMO));
                    check("timeout_ps2c_z", 32'(ps2c_w), 32'(1));
                    check("timeout_ps2d_z", 32'(ps2d_w), 32'(1));
                end else if (rx_q.size() == 0) begin
                    check("frame_missing", 32'(rx_q.size()), 32'(1));
                end else begin
                    mon_f = rx_q.pop_front();
                    check("frame_data", 32'(mon_f.data), 32'(mon_e.data));
                    check("frame_parity", 32'(mon_f.par), 32'(model_parity(mon_e.data)));
                    check("frame_stop", 32'(mon_f.stp), 32'(1));
                end
            end
        end
    end

    initial begin
        logic [7:0] b;
        bit ack;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_tx_idle", 32'(tx_idle), 32'(1));
        check("rst_ps2c_z", 32'(ps2c_w), 32'(1));
        check("rst_ps2d_z", 32'(ps2d_w), 32'(1));
        repeat (100) @(negedge clk);
        check("quiet_tx_idle", 32'(tx_idle), 32'(1));
        check("quiet_ps2c_z", 32'(ps2c_w), 32'(1));

        expect_result(8'hF4, K_DONE);
        issue(8'hF4, 1'b1);
        dev_xfer(11, 1'b1, 1'b0);
        wait_empty("f4_done");

        expect_result(8'hFF, K_NACK);
        issue(8'hFF, 1'b1);
        dev_xfer(11, 1'b0, 1'b0);
        wait_empty("ff_nack");

        issue(8'hAA, 1'b0);
        repeat (40) @(negedge clk);
        check("rxbusy_ps2c_z", 32'(ps2c_w), 32'(1));
        check("rxbusy_ps2d_z", 32'(ps2d_w), 32'(1));
        check("rxbusy_tx_idle", 32'(tx_idle), 32'(1));

        expect_result(8'h5A, K_DONE);
        issue(8'h5A, 1'b1);
        fork
            dev_xfer(11, 1'b1, 1'b0);
            begin
                repeat (120) @(negedge clk);
                din = 8'h00;
                wr_ps2 = 1'b1;
                @(negedge clk);
                wr_ps2 = 1'b0;
            end
        join
        wait_empty("busy_wr_ignored");

        expect_result(8'h3C, K_TMO);
        issue(8'h3C, 1'b1);
        dev_xfer(4, 1'b1, 1'b0);
        wait_empty("timeout");

        expect_result(8'hC3, K_DONE);
        issue(8'hC3, 1'b1);
        dev_xfer(11, 1'b1, 1'b1);
        wait_empty("glitch_done");

        issue(8'h00, 1'b1);
        dev_xfer(5, 1'b1, 1'b0);
        check("mid_data_ps2d_low", 32'(ps2d_w), 32'(0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ps2c_z", 32'(ps2c_w), 32'(1));
        check("midrst_ps2d_z", 32'(ps2d_w), 32'(1));
        check("midrst_tx_idle", 32'(tx_idle), 32'(1));
        repeat (20) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            ack = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            expect_result(b, ack ? K_DONE : K_NACK);
            issue(b, 1'b1);
            dev_xfer(11, ack, 1'($urandom_range(0, 1)));
            wait_empty("random_xfer");
        end

        repeat (20) @(negedge clk);
        check("rx_q_drained", 32'(rx_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_tx.md
Name: ps2_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xF4 "enable streaming", 0xFF "reset") from the FPGA to the mouse over the shared bidirectional ps2d/ps2c lines.
- Counterpart of the PS/2 receiver inside the mouse unit. Instantiated alongside it; its tx_idle gates the receiver while a transmission is in progress.
- The device generates all clocks after request-to-send. This block only drives lines low or releases them (open-drain via tristate).

Parameters:
- RTS_CYCLES, 5000, clk cycles ps2c is held low for request-to-send (100 us at 50 MHz).
- FILTER_LEN, 8, ps2c glitch-filter depth in clk samples.
- TIMEOUT_CYCLES, 1000000, max clk cycles between successive device clock falling edges before abort (20 ms at 50 MHz).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- wr_ps2  input  1  one-cycle strobe: start transmitting din.
- din  input  8  command byte, sampled only on the accepted wr_ps2 cycle.
- rx_idle  input  1  receiver idle (no frame being received).
- ps2d  inout  1  PS/2 data; driven 0 or high-Z, never driven 1.
- ps2c  inout  1  PS/2 clock; driven 0 or high-Z, never driven 1.
- tx_idle  output  1  high when in IDLE.
- tx_done_tick  output  1  one-cycle pulse: byte sent and device ack received.
- tx_err  output  1  one-cycle pulse: no ack (NACK) or timeout.

Behaviour:
Reset (synchronous, active-high):
- state=IDLE; ps2d and ps2c high-Z; tx_idle=1; tx_done_tick=0; tx_err=0.
- Filter register loaded all-ones; filtered clock=1.
- Asserting rst mid-frame releases both lines on the next clk edge and discards the frame.

Clock filter:
- FILTER_LEN-bit shift register of raw ps2c.
- Filtered clock goes 1 when all bits are 1, goes 0 when all bits are 0, otherwise holds.
- fall_edge is a registered one-cycle tick on a filtered 1->0 transition. Latency from raw edge: FILTER_LEN+1 cycles.

Frame:
- 9-bit shift register {odd parity, din[7:0]}; parity = ~^din.

States:
- IDLE: wr_ps2=1 with rx_idle=1 loads the frame register, loads the cycle counter with RTS_CYCLES-1, and goes to RTS. wr_ps2 while rx_idle=0 is ignored: no latch, no pulse.
- RTS: drive ps2c=0, ps2d released. Counter decrements each cycle; at 0 go to START.
  - Low time on ps2c is exactly RTS_CYCLES cycles.
- START: drive ps2d=0 (start bit), release ps2c. Bit counter n=8, timeout counter cleared.
  - On fall_edge go to DATA.
- DATA: ps2d driven 0 when frame[0]=0, released when 1. On fall_edge:
  - if n≠0: shift frame right, n=n-1.
  - if n=0: go to STOP.
  - Result: edges 1..9 present d0..d7 then parity; edge 10 leaves DATA.
- STOP: release ps2d (stop bit via pull-up). On fall_edge (edge 11) sample raw ps2d:
  - 0: tx_done_tick=1.
  - 1: tx_err=1.
  - Either way, go to IDLE.
- Timeout: in START/DATA/STOP a counter clears on every fall_edge and increments otherwise.
  - On reaching TIMEOUT_CYCLES: tx_err=1, release both lines, go to IDLE in the same cycle.

Outputs:
- tx_idle is combinational from state (1 only in IDLE). It drops the cycle after wr_ps2 is accepted.
- tx_done_tick and tx_err are mutually exclusive and are registered one-cycle pulses.

Boundary conditions:
- wr_ps2 while not in IDLE is ignored; din changes during a frame have no effect.
- fall_edge arriving in IDLE or RTS is ignored.
- A new wr_ps2 is accepted in the cycle after the done/err pulse.

Test Plan (bench overrides RTS_CYCLES=20, TIMEOUT_CYCLES=500, FILTER_LEN=8):
- Reset with lines pulled up -> both lines Z, tx_idle=1, no pulses for 100 cycles.
- wr_ps2 with din=0xF4, rx_idle=1 -> ps2c low exactly 20 cycles, then ps2d low (start bit).
  - Device model clocks 11 edges and samples on rising edges: d7..d0 read as 0xF4, parity=0, stop=1.
  - Model drives ack=0 -> exactly one tx_done_tick, tx_idle returns to 1.
- din=0xFF with model NACK (ps2d high at edge 11) -> parity=1 observed, tx_err pulse, no tx_done_tick.
- wr_ps2 with rx_idle=0 -> lines stay Z, tx_idle stays 1.
  - Second wr_ps2 during DATA with din=0x00 -> ignored; the original byte completes.
- Device model stops clocking after 4 edges -> tx_err exactly 500 cycles after the last fall_edge, both lines Z, state IDLE.
- Glitches of 1-7 cycles on ps2c during DATA -> no extra bit shifts, byte received intact.
  - rst asserted mid-DATA -> lines Z on next edge, no pulse; a subsequent command sends cleanly.
